// File: rtl/vpu_fp_dst_port.sv
// rtl/vpu_fp_dst_port.sv - VPU destination port: buffers ALU results and streams them to SRAM
//
// Purpose:
//   Accepts float ALU results through a valid/ready handshake into a small
//   FIFO. Drains the FIFO to consecutive SRAM word addresses through one write
//   port with backpressure. The controller arms a transfer with a base address
//   and an element count. done_o pulses once, the cycle after the last write
//   handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             one-cycle start pulse (honoured only in IDLE)
//   base_addr_i         first SRAM address, sampled on accepted start
//   elem_cnt_i          number of results to write, sampled on accepted start
//   result_i            ALU result data
//   result_valid_i      ALU result valid
//   result_ready_o      port accepts a result this cycle
//   sram_wr_en_o        SRAM write request
//   sram_wr_addr_o      SRAM write address
//   sram_wr_data_o      SRAM write data
//   sram_wr_ready_i     SRAM accepts the write this cycle
//   busy_o              transfer in progress
//   done_o              one-cycle completion pulse
module vpu_fp_dst_port #(
    parameter int OPERAND_WIDTH = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int CNT_WIDTH     = 11,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [CNT_WIDTH-1:0]     elem_cnt_i,
    input  logic [OPERAND_WIDTH-1:0] result_i,
    input  logic                     result_valid_i,
    output logic                     result_ready_o,
    output logic                     sram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]    sram_wr_addr_o,
    output logic [OPERAND_WIDTH-1:0] sram_wr_data_o,
    input  logic                     sram_wr_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [CNT_WIDTH-1:0]     elem_cnt_q, elem_cnt_d;
    logic [CNT_WIDTH-1:0]     acc_cnt_q, acc_cnt_d;
    logic [CNT_WIDTH-1:0]     wr_cnt_q, wr_cnt_d;
    // Pointers carry one extra bit so full and empty can be told apart.
    logic [PTR_W:0]           wptr_q, wptr_d;
    logic [PTR_W:0]           rptr_q, rptr_d;
    logic [OPERAND_WIDTH-1:0] mem_q [FIFO_DEPTH];
    // Last address/data shown on the write port, held while the FIFO is empty.
    logic [ADDR_WIDTH-1:0]    last_addr_q, last_addr_d;
    logic [OPERAND_WIDTH-1:0] last_data_q, last_data_d;

    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic [ADDR_WIDTH-1:0]    head_addr;
    logic [OPERAND_WIDTH-1:0] head_data;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

    // Ready depends only on registered state; it never looks at the SRAM side,
    // so a pop cannot open a slot for a push in the same cycle.
    assign result_ready_o = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q < elem_cnt_q);
    assign push           = result_valid_i && result_ready_o;

    assign sram_wr_en_o   = !fifo_empty;
    assign pop            = sram_wr_en_o && sram_wr_ready_i;

    // Address wraps modulo 2^ADDR_WIDTH by truncation.
    assign head_addr      = base_q + ADDR_WIDTH'(wr_cnt_q);
    assign head_data      = mem_q[rptr_q[PTR_W-1:0]];

    assign sram_wr_addr_o = fifo_empty ? last_addr_q : head_addr;
    assign sram_wr_data_o = fifo_empty ? last_data_q : head_data;

    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        elem_cnt_d  = elem_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        last_addr_d = sram_wr_addr_o;
        last_data_d = sram_wr_data_o;

        if (push) begin
            wptr_d = wptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (PTR_W+1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    elem_cnt_d = elem_cnt_i;
                    acc_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    state_d    = (elem_cnt_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (push) begin
                    acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
                end
                if (pop) begin
                    wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
                    if (wr_cnt_d == elem_cnt_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            elem_cnt_q  <= '0;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            elem_cnt_q  <= elem_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= result_i;
        end
    end

endmodule

// File: tb/tb_vpu_fp_dst_port.sv
// tb/tb_vpu_fp_dst_port.sv - self-checking bench for vpu_fp_dst_port
module tb_vpu_fp_dst_port;

    localparam int OW = 16;
    localparam int AW = 10;
    localparam int CW = 11;
    localparam int FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [CW-1:0] elem_cnt_i;
    logic [OW-1:0] result_i;
    logic          result_valid_i;
    logic          result_ready_o;
    logic          sram_wr_en_o;
    logic [AW-1:0] sram_wr_addr_o;
    logic [OW-1:0] sram_wr_data_o;
    logic          sram_wr_ready_i;
    logic          busy_o;
    logic          done_o;

    vpu_fp_dst_port #(
        .OPERAND_WIDTH(OW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .elem_cnt_i(elem_cnt_i), .result_i(result_i), .result_valid_i(result_valid_i),
        .result_ready_o(result_ready_o), .sram_wr_en_o(sram_wr_en_o),
        .sram_wr_addr_o(sram_wr_addr_o), .sram_wr_data_o(sram_wr_data_o),
        .sram_wr_ready_i(sram_wr_ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: transfer phase (0 idle, 1 running, 2 done pulse),
    // results held as a plain queue, counts of accepted and written results.
    int            m_phase;
    int            m_base, m_cnt, m_acc, m_wr;
    logic [OW-1:0] m_q[$];
    int            m_last_addr, m_last_data;

    logic [OW-1:0] src[$];
    int            src_idx;
    bit            check_en;
    bit            rand_hs;
    int            dut_push;
    logic [AW-1:0] log_addr[$];
    logic [OW-1:0] log_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit e_ready, e_wren, push, pop;
        int e_addr, e_data;
        if (rand_hs) begin
            result_valid_i  = ($urandom_range(0, 3) != 0);
            sram_wr_ready_i = ($urandom_range(0, 1) != 0);
        end
        result_i = (src_idx < src.size()) ? src[src_idx] : OW'($urandom);
        @(negedge clk);
        e_ready = (m_phase == 1) && (m_q.size() < FD) && (m_acc < m_cnt);
        e_wren  = (m_q.size() > 0);
        e_addr  = e_wren ? ((m_base + m_wr) % (1 << AW)) : m_last_addr;
        e_data  = e_wren ? int'(m_q[0]) : m_last_data;
        if (check_en) begin
            chk("ready", 32'(result_ready_o), 32'(e_ready));
            chk("wr_en", 32'(sram_wr_en_o), 32'(e_wren));
            chk("wr_addr", 32'(sram_wr_addr_o), 32'(e_addr));
            chk("wr_data", 32'(sram_wr_data_o), 32'(e_data));
            chk("busy", 32'(busy_o), 32'(m_phase != 0));
            chk("done", 32'(done_o), 32'(m_phase == 2));
        end
        if (result_valid_i && result_ready_o) dut_push++;
        if (sram_wr_en_o && sram_wr_ready_i) begin
            log_addr.push_back(sram_wr_addr_o);
            log_data.push_back(sram_wr_data_o);
        end
        push = result_valid_i && e_ready;
        pop  = e_wren && sram_wr_ready_i;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_q.delete(); m_last_addr = 0; m_last_data = 0;
            m_acc = 0; m_wr = 0;
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    m_base = int'(base_addr_i); m_cnt = int'(elem_cnt_i);
                    m_acc = 0; m_wr = 0;
                    m_phase = (m_cnt == 0) ? 2 : 1;
                end
                1: begin
                    if (pop) begin
                        m_last_addr = e_addr; m_last_data = e_data;
                        void'(m_q.pop_front());
                        m_wr++;
                    end
                    if (push) begin
                        m_q.push_back(result_i);
                        m_acc++;
                        src_idx++;
                    end
                    if (m_wr == m_cnt) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic fill_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(OW'($urandom));
    endtask

    task automatic start_xfer(input int base, input int cnt);
        src_idx = 0; dut_push = 0;
        log_addr.delete(); log_data.delete();
        base_addr_i = AW'(base); elem_cnt_i = CW'(cnt); start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (m_phase != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        if (n >= max_cycles) begin
            checks++; failures++;
            $error("FAIL timeout observed=%0d expected<%0d", n, max_cycles);
        end
        tick();
    endtask

    task automatic chk_log(input string tag, input int base, input int cnt);
        chk({tag, "_count"}, 32'(log_addr.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < log_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(log_addr[i]), 32'((base + i) % (1 << AW)));
            if (i < src.size()) chk({tag, "_data"}, 32'(log_data[i]), 32'(src[i]));
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; elem_cnt_i = '0;
        result_i = '0; result_valid_i = 1'b0; sram_wr_ready_i = 1'b0;
        check_en = 1'b0; rand_hs = 1'b0; src_idx = 0; dut_push = 0;
        m_phase = 0; m_base = 0; m_cnt = 0; m_acc = 0; m_wr = 0;
        m_last_addr = 0; m_last_data = 0;
        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Basic stream
        src.delete();
        src.push_back(16'h3F80); src.push_back(16'h4000);
        src.push_back(16'h4040); src.push_back(16'h4080);
        result_valid_i = 1'b1; sram_wr_ready_i = 1'b1;
        start_xfer(32'h010, 4);
        wait_idle(40);
        chk_log("basic", 32'h010, 4);

        // Backpressure: only the FIFO depth gets accepted while SRAM stalls
        fill_src(8);
        result_valid_i = 1'b1; sram_wr_ready_i = 1'b0;
        start_xfer(32'h080, 8);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_accepted", 32'(dut_push), 32'(FD));
        sram_wr_ready_i = 1'b1;
        wait_idle(60);
        chk_log("bp", 32'h080, 8);

        // Address wrap with random handshakes
        fill_src(4);
        rand_hs = 1'b1;
        start_xfer(32'h3FE, 4);
        wait_idle(200);
        rand_hs = 1'b0;
        chk_log("wrap", 32'h3FE, 4);

        // Zero count
        fill_src(2);
        result_valid_i = 1'b1; sram_wr_ready_i = 1'b1;
        start_xfer(32'h050, 0);
        wait_idle(10);
        chk("zero_writes", 32'(log_addr.size()), 32'd0);
        chk("zero_accepts", 32'(dut_push), 32'd0);

        // Excess results offered
        fill_src(5);
        start_xfer(32'h060, 2);
        for (int i = 0; i < 8; i++) tick();
        chk("excess_accepts", 32'(dut_push), 32'd2);
        chk_log("excess", 32'h060, 2);

        // Reset mid-transfer: 3 accepted, 1 written, then reset
        fill_src(6);
        result_valid_i = 1'b1; sram_wr_ready_i = 1'b0;
        start_xfer(32'h200, 6);
        for (int i = 0; i < 20 && m_acc < 3; i++) tick();
        result_valid_i = 1'b0; sram_wr_ready_i = 1'b1;
        tick();
        sram_wr_ready_i = 1'b0;
        chk("rst_mid_accepts", 32'(dut_push), 32'd3);
        chk("rst_mid_writes", 32'(log_addr.size()), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        fill_src(1);
        result_valid_i = 1'b1; sram_wr_ready_i = 1'b1;
        start_xfer(32'h300, 1);
        wait_idle(20);
        chk_log("after_rst", 32'h300, 1);

        // Start while busy is ignored
        fill_src(5);
        rand_hs = 1'b1;
        start_xfer(32'h020, 5);
        tick();
        base_addr_i = AW'(32'h100); elem_cnt_i = CW'(9); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_idle(200);
        rand_hs = 1'b0;
        chk_log("busy_start", 32'h020, 5);

        // Random transfers
        for (int t = 0; t < 4; t++) begin
            int b, c;
            b = $urandom_range(0, (1 << AW) - 1);
            c = $urandom_range(1, 12);
            fill_src(c);
            rand_hs = 1'b1;
            start_xfer(b, c);
            wait_idle(400);
            rand_hs = 1'b0;
            chk_log("rand", b, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vpu_fp_dst_port.md
Name: vpu_fp_dst_port

Overview:
Destination-side port of the VPU. It consumes per-cycle results from the float ALU bank (max/avg/add units) through a valid/ready handshake and buffers them in a small FIFO. It writes them to consecutive SRAM addresses through one SRAM write port with backpressure. VPU_CONTROLLER arms it with a base address and element count, and receives a done pulse after the last write.

Parameters:
OPERAND_WIDTH, 16, result/data width (bf16), equals VPU_PKG::OPERAND_WIDTH
ADDR_WIDTH, 10, SRAM word address width
CNT_WIDTH, 11, element counter width (max count 2^CNT_WIDTH-1)
FIFO_DEPTH, 4, result buffer entries; power of two, >=2

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_i  input  1  one-cycle pulse from VPU_CONTROLLER to begin a transfer
base_addr_i  input  ADDR_WIDTH  first SRAM address, sampled on accepted start
elem_cnt_i  input  CNT_WIDTH  number of results to write, sampled on accepted start
result_i  input  OPERAND_WIDTH  ALU result
result_valid_i  input  1  result_i valid
result_ready_o  output  1  port accepts result this cycle
sram_wr_en_o  output  1  SRAM write request
sram_wr_addr_o  output  ADDR_WIDTH  SRAM write address
sram_wr_data_o  output  OPERAND_WIDTH  SRAM write data
sram_wr_ready_i  input  1  SRAM accepts write this cycle
busy_o  output  1  transfer in progress
done_o  output  1  one-cycle pulse when the last write completes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, FIFO empty, counters 0. All outputs are 0: result_ready_o, sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o, busy_o, done_o. Reset asserted mid-transfer aborts the transfer, flushes the FIFO, and produces no done pulse.
- States:
  - IDLE: start_i moves to RUN. On the same edge it latches base_addr_i and elem_cnt_i and clears acc_cnt and wr_cnt. If elem_cnt_i==0, it goes to DONE instead.
  - RUN: accepts results and writes. When wr_cnt reaches elem_cnt, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o = (state != IDLE).
- start_i outside IDLE is ignored and has no side effects.
- Input handshake: result_ready_o = (state==RUN) && !fifo_full && (acc_cnt < elem_cnt). This is a registered-state function with no combinational path from sram_wr_ready_i.
  - Push when result_valid_i && result_ready_o, then acc_cnt++.
  - Results offered beyond elem_cnt are never accepted; ready stays 0.
- Write side:
  - sram_wr_en_o = !fifo_empty.
  - sram_wr_data_o = FIFO head.
  - sram_wr_addr_o = base_addr + wr_cnt, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
  - When sram_wr_en_o && sram_wr_ready_i: pop and wr_cnt++.
  - Address and data hold stable while wr_en=1 and ready=0.
  - When the FIFO is empty, sram_wr_addr_o/sram_wr_data_o hold their last values.
- Latency: a result accepted at edge N appears on sram_wr_en_o in cycle N+1, with no bypass. Sustained throughput is 1 result/cycle when sram_wr_ready_i=1.
- Simultaneous push and pop: allowed in the same cycle; occupancy is unchanged.
- FIFO full: ready drops. A pop in that cycle does not allow a push in the same cycle; ready rises the next cycle.
- Pointers: wrap modulo FIFO_DEPTH, with full/empty derived from an extra pointer bit.
- done_o asserts the cycle after the final write handshake.

Test Plan:
- Basic stream: base=0x010, cnt=4, valid=1 and sram_wr_ready_i=1 throughout, data 0x3F80/0x4000/0x4040/0x4080 -> writes to 0x010..0x013 in consecutive cycles, first wr_en one cycle after the first accept, done_o a single pulse one cycle after the last write, busy_o low afterwards.
- Backpressure: cnt=8, sram_wr_ready_i=0 for 10 cycles -> exactly 4 results accepted, then result_ready_o=0; wr_addr/data stable. On release, all 8 writes occur in order with no loss or duplication.
- Address wrap: ADDR_WIDTH=10, base=0x3FE, cnt=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Zero count and excess results: cnt=0 -> done_o the cycle after start with no writes and ready never high. cnt=2 with 5 valid results offered -> only 2 accepted and written.
- Reset mid-operation: rst=1 after 3 of 6 results are accepted and 1 written -> next cycle all outputs 0, FIFO empty, no done_o. A new start with cnt=1 completes normally.
- Start while busy: a second start_i with base=0x100 during RUN -> ignored; the original transfer's addresses and count are unaffected.
